afe_spi_attenuator_driver: RTL and testbench
============================================

Name: afe_spi_attenuator_driver

Overview:
- Write-only serial driver for the AFE step-attenuator chain; produces the AFE_SPI_CLK/SDI/LE pin vectors of the top level, one lane per AFE.
- The processor issues a word plus a lane index through a CSR strobe. A single shared state machine shifts the word out on the selected lane, then pulses that lane's latch enable.
- Busy and error status are read back through a status word.

Parameters:
- CLK_RATE, 99999001, sysClk frequency in Hz.
- SPI_RATE, 1000000, target serial clock in Hz.
- HALF_TICKS, ceil(CLK_RATE/(2*SPI_RATE)) (=50), sysClk cycles per SPI half period; must be >= 2.
- WORD_WIDTH, 16, bits shifted per transaction (1..24).
- CHANNEL_COUNT, 2, number of AFE lanes (1..4).
- MSB_FIRST, "TRUE", bit order; "FALSE" gives LSB first.

Ports:
- sysClk  in  1  sole clock; all logic is on its rising edge.
- sysReset  in  1  synchronous, active-high reset.
- csrStrobe  in  1  single-cycle write request.
- GPIO_OUT  in  32  [WORD_WIDTH-1:0] = data; [25:24] = lane index; other bits ignored.
- status  out  32  [31] busy, [30] overrun (sticky), [29] badLane (sticky), [28:26] 0, [25:24] last lane, [WORD_WIDTH-1:0] last accepted word, remaining bits 0.
- AFE_SPI_CLK  out  CHANNEL_COUNT  serial clock per lane; idles low.
- AFE_SPI_SDI  out  CHANNEL_COUNT  serial data per lane.
- AFE_SPI_LE  out  CHANNEL_COUNT  latch enable per lane; active-high pulse.

Behaviour:
- Reset values: all status bits 0; AFE_SPI_CLK, SDI and LE all 0; FSM in IDLE; divider and bit counter 0.
- Reset mid-transaction: all outputs return to reset values on that edge. No partial LE pulse is ever issued.
- FSM states: IDLE, CLK_LO, CLK_HI, LE_GAP, LE_HI. Each non-IDLE state lasts exactly HALF_TICKS cycles, counted by the divider.
- Accepted write: csrStrobe with busy=0 and lane < CHANNEL_COUNT.
  - On the strobe edge: capture the word into the shift register and the lane into the lane register; set busy; clear overrun and badLane; go to CLK_LO.
  - busy reads 1 from the cycle after the strobe.
- CLK_LO: SDI[lane] is driven with the current bit on entry and held through CLK_HI. CLK[lane] is 0. Next state is CLK_HI.
- CLK_HI: CLK[lane] is 1.
  - At the end of the state, shift the register and increment the bit counter.
  - If WORD_WIDTH bits have been sent, go to LE_GAP; otherwise go to CLK_LO.
- Data changes only while CLK is low, so the peripheral samples on the rising edge.
- LE_GAP: CLK is 0; SDI is held at the last bit.
- LE_HI: LE[lane] is 1. At the end of the state: LE=0, SDI=0, busy=0, FSM returns to IDLE.
- Transaction length: from strobe to busy falling is (2*WORD_WIDTH+2)*HALF_TICKS cycles; busy is 1 for exactly that many cycles.
- Non-selected lanes keep CLK, SDI and LE at 0 for the whole transaction.
- Strobe while busy: ignored and sets overrun=1. The transaction in flight is unaffected.
- Strobe with lane >= CHANNEL_COUNT: ignored and sets badLane=1. No pin activity; busy stays 0.
- Strobe in the cycle busy falls (LE_HI to IDLE edge): busy is still 1 on that edge, so it counts as overrun.
- Strobe in the following cycle (busy=0): accepted.
- Bit order: with MSB_FIRST="TRUE", bit WORD_WIDTH-1 goes first; otherwise bit 0 goes first.

Test Plan:
- Setup for all scenarios: CLK_RATE=8, SPI_RATE=1 (HALF_TICKS=4), WORD_WIDTH=16, CHANNEL_COUNT=2.
- Basic write: write 0xA5C3 to lane 1 -> SDI[1] sampled at the 16 CLK[1] rising edges reads 1010010111000011. CLK[1] period is 8 cycles. One LE[1] pulse of 4 cycles starts 4 cycles after the last CLK fall. busy is high for 136 cycles. Lane 0 pins stay 0 throughout. status[15:0]=0xA5C3 and status[25:24]=1.
- LSB first: MSB_FIRST="FALSE", write 0x0001 to lane 0 -> first sampled bit is 1 and the remaining 15 are 0.
- Overrun: write to lane 0, then strobe 0xFFFF at cycle 20 -> the original word completes untouched and overrun=1. The next accepted write clears overrun.
- Bad lane: GPIO_OUT[25:24]=2 -> no pin toggles, busy stays 0, badLane=1.
- Reset mid-operation: assert sysReset at cycle 30 of a transaction -> on the next edge all pins are 0 and status=0, and LE never pulses. A write after reset completes normally.
- Back-to-back boundary: strobe on the busy-falling edge -> overrun, ignored. Strobe one cycle later -> accepted, with no glitch on LE or CLK between the two transactions.

Source files
------------

// File: rtl/afe_spi_attenuator_driver_if.sv
// CSR-side bus of the AFE attenuator driver: write strobe, data/lane word, status.
interface afe_spi_attenuator_driver_if;
  logic        csrStrobe;
  logic [31:0] GPIO_OUT;
  logic [31:0] status;

  modport master (output csrStrobe, output GPIO_OUT, input status);
  modport slave  (input csrStrobe, input GPIO_OUT, output status);
endinterface

// File: rtl/afe_spi_attenuator_driver.sv
// Write-only serial driver for the AFE step-attenuator chain. One shared FSM
// shifts a word out on the selected lane, then pulses that lane's latch enable.
module afe_spi_attenuator_driver #(
  parameter int    CLK_RATE      = 99999001,
  parameter int    SPI_RATE      = 1000000,
  parameter int    HALF_TICKS    = (CLK_RATE + 2 * SPI_RATE - 1) / (2 * SPI_RATE),
  parameter int    WORD_WIDTH    = 16,
  parameter int    CHANNEL_COUNT = 2,
  parameter string MSB_FIRST     = "TRUE"
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  afe_spi_attenuator_driver_if.slave csr,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
);

  localparam bit          MSB    = (MSB_FIRST == "TRUE");
  localparam int          DIV_W  = $clog2(HALF_TICKS);
  localparam int          CNT_W  = $clog2(WORD_WIDTH + 1);
  localparam logic [2:0]  CH_CNT = 3'(CHANNEL_COUNT);

  typedef enum logic [2:0] {IDLE, CLK_LO, CLK_HI, LE_GAP, LE_HI} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q;
  logic [CNT_W-1:0]      bit_q;
  logic [WORD_WIDTH-1:0] shreg_q;
  logic [WORD_WIDTH-1:0] shifted;
  logic [WORD_WIDTH-1:0] last_word_q;
  logic [1:0]            lane_q;
  logic                  sdi_q;
  logic                  ovr_q;
  logic                  bad_q;

  logic       busy;
  logic       div_end;
  logic       last_bit;
  logic [1:0] lane_in;
  logic       lane_ok;
  logic       accept;
  logic       unused_gpio;

  function automatic logic head(input logic [WORD_WIDTH-1:0] v);
    return MSB ? v[WORD_WIDTH-1] : v[0];
  endfunction

  assign busy        = (state_q != IDLE);
  assign div_end     = (div_q == DIV_W'(HALF_TICKS - 1));
  assign last_bit    = (bit_q == CNT_W'(WORD_WIDTH - 1));
  assign lane_in     = csr.GPIO_OUT[25:24];
  assign lane_ok     = ({1'b0, lane_in} < CH_CNT);
  assign accept      = csr.csrStrobe && !busy && lane_ok;
  assign shifted     = MSB ? (shreg_q << 1) : (shreg_q >> 1);
  assign unused_gpio = ^csr.GPIO_OUT;

  // FSM state register
  always_ff @(posedge sysClk) begin
    if (sysReset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: every non-idle state lasts one divider period
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)  state_d = CLK_LO;
      CLK_LO:  if (div_end) state_d = CLK_HI;
      CLK_HI:  if (div_end) state_d = last_bit ? LE_GAP : CLK_LO;
      LE_GAP:  if (div_end) state_d = LE_HI;
      LE_HI:   if (div_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider, shift register, bit counter, serial data and sticky status flags
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      div_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      last_word_q <= '0;
      lane_q      <= '0;
      sdi_q       <= 1'b0;
      ovr_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      if (!busy)        div_q <= '0;
      else if (div_end) div_q <= '0;
      else              div_q <= div_q + 1'b1;

      if (accept) begin
        shreg_q     <= csr.GPIO_OUT[WORD_WIDTH-1:0];
        last_word_q <= csr.GPIO_OUT[WORD_WIDTH-1:0];
        lane_q      <= lane_in;
        sdi_q       <= head(csr.GPIO_OUT[WORD_WIDTH-1:0]);
        bit_q       <= '0;
        ovr_q       <= 1'b0;
        bad_q       <= 1'b0;
      end else if (csr.csrStrobe) begin
        if (busy) ovr_q <= 1'b1;
        else      bad_q <= 1'b1;
      end

      // SDI only moves on the CLK_HI->CLK_LO edge; after the last bit it is
      // held through LE_GAP/LE_HI rather than following the shifted register.
      if (state_q == CLK_HI && div_end) begin
        bit_q   <= bit_q + 1'b1;
        shreg_q <= shifted;
        if (!last_bit) sdi_q <= head(shifted);
      end
      if (state_q == LE_HI && div_end) sdi_q <= 1'b0;
    end
  end

  // Pin fan-out: only the latched lane ever sees activity
  always_comb begin
    AFE_SPI_CLK = '0;
    AFE_SPI_SDI = '0;
    AFE_SPI_LE  = '0;
    for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
      if (lane_q == 2'(i)) begin
        AFE_SPI_CLK[i] = (state_q == CLK_HI);
        AFE_SPI_SDI[i] = sdi_q;
        AFE_SPI_LE[i]  = (state_q == LE_HI);
      end
    end
  end

  // Status word assembly
  always_comb begin
    csr.status                   = '0;
    csr.status[31]               = busy;
    csr.status[30]               = ovr_q;
    csr.status[29]               = bad_q;
    csr.status[25:24]            = lane_q;
    csr.status[WORD_WIDTH-1:0]   = last_word_q;
  end

endmodule

// File: tb/tb_afe_spi_attenuator_driver.sv
// Bench for afe_spi_attenuator_driver: an MSB-first and an LSB-first instance
// checked every cycle against a transaction-timing model, plus directed scenarios.
module tb_afe_spi_attenuator_driver;
  localparam int W    = 16;
  localparam int H    = 4;
  localparam int NCH  = 2;
  localparam int TLEN = (2 * W + 2) * H;

  logic sysClk = 1'b0;
  logic sysReset;
  always #5 sysClk = ~sysClk;

  afe_spi_attenuator_driver_if bus0 ();
  afe_spi_attenuator_driver_if bus1 ();

  logic [NCH-1:0] pin_clk [2];
  logic [NCH-1:0] pin_sdi [2];
  logic [NCH-1:0] pin_le  [2];

  afe_spi_attenuator_driver #(
    .CLK_RATE(8), .SPI_RATE(1), .WORD_WIDTH(W), .CHANNEL_COUNT(NCH), .MSB_FIRST("TRUE")
  ) u_msb (
    .sysClk(sysClk), .sysReset(sysReset), .csr(bus0),
    .AFE_SPI_CLK(pin_clk[0]), .AFE_SPI_SDI(pin_sdi[0]), .AFE_SPI_LE(pin_le[0])
  );

  afe_spi_attenuator_driver #(
    .CLK_RATE(8), .SPI_RATE(1), .WORD_WIDTH(W), .CHANNEL_COUNT(NCH), .MSB_FIRST("FALSE")
  ) u_lsb (
    .sysClk(sysClk), .sysReset(sysReset), .csr(bus1),
    .AFE_SPI_CLK(pin_clk[1]), .AFE_SPI_SDI(pin_sdi[1]), .AFE_SPI_LE(pin_le[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: elapsed cycles of the transaction in flight (-1 = idle)
  int          m_t    [2];
  logic [15:0] m_word [2];
  logic [1:0]  m_lane [2];
  bit          m_ovr  [2];
  bit          m_bad  [2];

  // monitor
  logic [31:0]    cap_w    [2];
  int             cap_n    [2];
  int             busy_n   [2];
  int             le_pulses[2];
  int             le_hi    [2];
  int             le_rise  [2];
  int             last_fall[2];
  int             rise_first[2];
  int             rise_last[2];
  logic [NCH-1:0] act      [2];
  logic [NCH-1:0] prev_clk [2];
  logic [NCH-1:0] prev_le  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] req(input logic [1:0] lane, input logic [15:0] w);
    return {6'b0, lane, 8'h00, w};
  endfunction

  function automatic logic [31:0] status_of(input int k);
    return (k == 0) ? bus0.status : bus1.status;
  endfunction

  task automatic set_req(input int k, input logic s, input logic [31:0] d);
    if (k == 0) begin bus0.csrStrobe = s; bus0.GPIO_OUT = d; end
    else        begin bus1.csrStrobe = s; bus1.GPIO_OUT = d; end
  endtask

  function automatic logic [31:0] exp_status(input int k);
    return {(m_t[k] >= 0), m_ovr[k], m_bad[k], 3'b000, m_lane[k], 8'h00, m_word[k]};
  endfunction

  // Expected pins from elapsed time: 2W clock half-periods, then gap, then LE.
  task automatic exp_pins(input int k, output logic [NCH-1:0] c, output logic [NCH-1:0] s,
                          output logic [NCH-1:0] l);
    int   ph;
    int   b;
    logic bv;
    c = '0; s = '0; l = '0;
    if (m_t[k] >= 0) begin
      ph = m_t[k] / H;
      b  = (ph < 2 * W) ? ph / 2 : W - 1;
      bv = (k == 0) ? m_word[k][W-1-b] : m_word[k][b];
      s[m_lane[k]] = bv;
      if (ph < 2 * W && ph % 2 == 1) c[m_lane[k]] = 1'b1;
      if (ph == 2 * W + 1)           l[m_lane[k]] = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic [31:0] g;
    logic        st;
    bit          was_busy;
    for (int k = 0; k < 2; k++) begin
      g  = (k == 0) ? bus0.GPIO_OUT : bus1.GPIO_OUT;
      st = (k == 0) ? bus0.csrStrobe : bus1.csrStrobe;
      if (sysReset) begin
        m_t[k] = -1; m_word[k] = '0; m_lane[k] = '0; m_ovr[k] = 0; m_bad[k] = 0;
      end else begin
        was_busy = (m_t[k] >= 0);
        if (was_busy) begin
          m_t[k]++;
          if (m_t[k] == TLEN) m_t[k] = -1;
        end
        if (st) begin
          if (was_busy)              m_ovr[k] = 1;
          else if (g[25:24] >= NCH)  m_bad[k] = 1;
          else begin
            m_t[k] = 0; m_word[k] = g[15:0]; m_lane[k] = g[25:24];
            m_ovr[k] = 0; m_bad[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      cap_w[k] = '0; cap_n[k] = 0; busy_n[k] = 0; le_pulses[k] = 0; le_hi[k] = 0;
      le_rise[k] = 0; last_fall[k] = 0; rise_first[k] = -1; rise_last[k] = 0; act[k] = '0;
    end
  endtask

  // One clock: model advances on the edge, everything is compared half a period later.
  task automatic cycle();
    logic [NCH-1:0] ec, es, el;
    @(posedge sysClk);
    model_edge();
    cyc++;
    @(negedge sysClk);
    for (int k = 0; k < 2; k++) begin
      exp_pins(k, ec, es, el);
      check($sformatf("status%0d", k), status_of(k), exp_status(k));
      check($sformatf("clk%0d", k), 32'(pin_clk[k]), 32'(ec));
      check($sformatf("sdi%0d", k), 32'(pin_sdi[k]), 32'(es));
      check($sformatf("le%0d", k),  32'(pin_le[k]),  32'(el));
      for (int l = 0; l < NCH; l++) begin
        if (pin_clk[k][l] && !prev_clk[k][l]) begin
          cap_w[k] = {cap_w[k][30:0], pin_sdi[k][l]};
          cap_n[k]++;
          if (rise_first[k] < 0) rise_first[k] = cyc;
          rise_last[k] = cyc;
        end
        if (!pin_clk[k][l] && prev_clk[k][l]) last_fall[k] = cyc;
        if (pin_le[k][l] && !prev_le[k][l]) begin le_pulses[k]++; le_rise[k] = cyc; end
      end
      if (|pin_le[k]) le_hi[k]++;
      if (status_of(k)[31]) busy_n[k]++;
      act[k]      = act[k] | pin_clk[k] | pin_sdi[k] | pin_le[k];
      prev_clk[k] = pin_clk[k];
      prev_le[k]  = pin_le[k];
    end
    bus0.csrStrobe = 1'b0;
    bus1.csrStrobe = 1'b0;
  endtask

  initial begin
    logic [15:0] w, w2, w3;
    sysReset = 1'b1;
    bus0.csrStrobe = 1'b0; bus0.GPIO_OUT = '0;
    bus1.csrStrobe = 1'b0; bus1.GPIO_OUT = '0;
    for (int k = 0; k < 2; k++) begin prev_clk[k] = '0; prev_le[k] = '0; end
    clear_mon();
    repeat (3) cycle();
    sysReset = 1'b0;
    cycle();
    check("reset_status", bus0.status, 32'h0);
    check("reset_pins", {26'b0, pin_clk[0], pin_sdi[0], pin_le[0]}, 32'h0);

    // basic write (lane 1, MSB first) and LSB-first single bit (lane 0)
    clear_mon();
    set_req(0, 1'b1, req(2'd1, 16'hA5C3));
    set_req(1, 1'b1, req(2'd0, 16'h0001));
    repeat (TLEN + 4) cycle();
    check("basic_bits", cap_w[0], 32'h0000A5C3);
    check("basic_nbits", cap_n[0], 16);
    check("basic_period", rise_last[0] - rise_first[0], 15 * 8);
    check("basic_busy_len", busy_n[0], TLEN);
    check("basic_le_pulses", le_pulses[0], 1);
    check("basic_le_width", le_hi[0], H);
    check("basic_le_gap", le_rise[0] - last_fall[0], H);
    check("basic_lane_act", 32'(act[0]), 32'h2);
    check("basic_st_word", {16'h0, bus0.status[15:0]}, 32'h0000A5C3);
    check("basic_st_lane", {30'h0, bus0.status[25:24]}, 32'h1);
    check("lsb_bits", cap_w[1], 32'h00008000);
    check("lsb_nbits", cap_n[1], 16);

    // overrun at cycle 20
    clear_mon();
    w = 16'($urandom);
    set_req(0, 1'b1, req(2'd0, w));
    cycle();
    repeat (19) cycle();
    set_req(0, 1'b1, req(2'd0, 16'hFFFF));
    cycle();
    repeat (TLEN) cycle();
    check("ovr_bits", cap_w[0], {16'h0, w});
    check("ovr_flag", {31'h0, bus0.status[30]}, 32'h1);
    check("ovr_word", {16'h0, bus0.status[15:0]}, {16'h0, w});
    set_req(0, 1'b1, req(2'($urandom_range(0, 1)), 16'($urandom)));
    cycle();
    check("ovr_cleared", {31'h0, bus0.status[30]}, 32'h0);
    repeat (TLEN) cycle();

    // bad lane
    clear_mon();
    set_req(0, 1'b1, req(2'd2, 16'($urandom)));
    set_req(1, 1'b1, req(2'd3, 16'($urandom)));
    repeat (12) cycle();
    check("bad_busy", busy_n[0], 0);
    check("bad_act", 32'(act[0]), 32'h0);
    check("bad_flag", {31'h0, bus0.status[29]}, 32'h1);
    check("bad_flag_lsb", {31'h0, bus1.status[29]}, 32'h1);

    // reset mid-transaction
    clear_mon();
    set_req(0, 1'b1, req(2'd1, 16'($urandom)));
    cycle();
    repeat (29) cycle();
    sysReset = 1'b1;
    cycle();
    sysReset = 1'b0;
    check("rst_mid_status", bus0.status, 32'h0);
    check("rst_mid_pins", {26'b0, pin_clk[0], pin_sdi[0], pin_le[0]}, 32'h0);
    repeat (TLEN) cycle();
    check("rst_mid_no_le", le_pulses[0], 0);
    clear_mon();
    w2 = 16'($urandom);
    set_req(0, 1'b1, req(2'd1, w2));
    repeat (TLEN + 2) cycle();
    check("rst_after_bits", cap_w[0], {16'h0, w2});
    check("rst_after_le", le_pulses[0], 1);

    // back-to-back boundary
    clear_mon();
    w  = 16'($urandom);
    w3 = 16'($urandom);
    set_req(0, 1'b1, req(2'd0, w));
    cycle();
    repeat (TLEN - 1) cycle();
    set_req(0, 1'b1, req(2'd1, 16'($urandom)));
    cycle();
    check("b2b_edge_ovr", {30'h0, bus0.status[31:30]}, 32'h1);
    set_req(0, 1'b1, req(2'd1, w3));
    cycle();
    check("b2b_accept", {30'h0, bus0.status[31:30]}, 32'h2);
    repeat (TLEN) cycle();
    check("b2b_bits", cap_w[0], {w, w3});
    check("b2b_le_pulses", le_pulses[0], 2);
    check("b2b_le_width", le_hi[0], 2 * H);

    // randomized traffic, including random lanes, collisions and resets
    repeat (3000) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 39) == 0) set_req(k, 1'b1, $urandom);
      sysReset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    sysReset = 1'b0;
    repeat (TLEN) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
